// File: rtl/mmio_interconnect.sv
// mmio_interconnect: decodes CPU data-port accesses onto N_CH synchronous-read
// memory channels and a small control register block (CTRL, STATUS, WCNT[k]).
// Reads take two cycles (stall, then data); writes complete in one cycle.
// Ports:
//   clk, reset (async, active-low)
//   cpu_adr/cpu_wdata/cpu_we/cpu_re -> CPU request; cpu_rdata/cpu_ready <- response
//   ch_adr/ch_wdata/ch_we -> shared channel request; ch_rdata <- flat channel read data
//   vga  : CTRL bit0 show flag
//   err  : sticky unmapped/conflicting-access flag (STATUS bit0)
module mmio_interconnect #(
  parameter int unsigned       DATA_W    = 24,
  parameter int unsigned       ADDR_W    = 24,
  parameter int unsigned       N_CH      = 3,
  parameter int unsigned       CH_AW     = 18,
  parameter logic [ADDR_W-1:0] CH_BASE   = 24'h040000,
  parameter logic [ADDR_W-1:0] CTRL_BASE = 24'h000000,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      cpu_adr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  input  logic                   cpu_we,
  input  logic                   cpu_re,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_ready,
  output logic [CH_AW-1:0]       ch_adr,
  output logic [DATA_W-1:0]      ch_wdata,
  output logic [N_CH-1:0]        ch_we,
  input  logic [N_CH*DATA_W-1:0] ch_rdata,
  output logic                   vga,
  output logic                   err
);

  localparam int unsigned IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CTRL_N = 2 + N_CH;
  localparam int unsigned COFF_W = 4;
  localparam longint unsigned TOP_END = longint'(CH_BASE) + (longint'(N_CH) << CH_AW);

  // Reject configurations whose channel map would wrap or exceed supported sizes.
  if (N_CH < 1 || N_CH > 8 || CH_AW >= ADDR_W || CNT_W > DATA_W ||
      TOP_END > (64'd1 << ADDR_W)) begin : g_bad_cfg
    $error("mmio_interconnect: illegal parameter set");
  end

  typedef enum logic {ST_IDLE, ST_RWAIT} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rd_is_ch_q, rd_is_ch_d;
  logic                rd_is_ctrl_q, rd_is_ctrl_d;
  logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
  logic [COFF_W-1:0]   rd_off_q, rd_off_d;
  logic                vga_q, vga_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    wcnt_q [N_CH];
  logic [CNT_W-1:0]    wcnt_d [N_CH];

  logic [ADDR_W:0]     ch_diff, ctrl_diff;
  logic [ADDR_W-1:0]   ch_off, ch_idx_full;
  logic [IDX_W-1:0]    ch_idx;
  logic [COFF_W-1:0]   ctrl_off;
  logic                hit_any_ch, hit_ctrl, unmapped, wr_ctrl, err_evt;
  logic [N_CH-1:0]     hit_ch, ch_we_c;
  logic [DATA_W-1:0]   ch_rd, ctrl_rd, rd_mux;

  // Region decode; the extra MSB of each difference flags addresses below the base.
  always_comb begin
    ch_diff     = {1'b0, cpu_adr} - {1'b0, CH_BASE};
    ch_off      = ch_diff[ADDR_W-1:0];
    ch_idx_full = ch_off >> CH_AW;
    hit_any_ch  = !ch_diff[ADDR_W] && (ch_idx_full < ADDR_W'(N_CH));
    ch_idx      = IDX_W'(ch_idx_full);
    for (int k = 0; k < N_CH; k++) begin
      hit_ch[k] = hit_any_ch && (ch_idx_full == ADDR_W'(k));
    end
    ctrl_diff = {1'b0, cpu_adr} - {1'b0, CTRL_BASE};
    hit_ctrl  = !ctrl_diff[ADDR_W] && (ctrl_diff[ADDR_W-1:0] < ADDR_W'(CTRL_N));
    ctrl_off  = COFF_W'(ctrl_diff[ADDR_W-1:0]);
    unmapped  = !hit_any_ch && !hit_ctrl;
    ch_we_c   = cpu_we ? hit_ch : '0;
  end

  // Read data selection from the target captured at the start of the read.
  always_comb begin
    ch_rd   = '0;
    ctrl_rd = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (rd_idx_q == IDX_W'(k)) ch_rd = ch_rdata[k*DATA_W +: DATA_W];
    end
    if (rd_off_q == COFF_W'(0)) begin
      ctrl_rd[0] = vga_q;
    end else if (rd_off_q == COFF_W'(1)) begin
      ctrl_rd[0] = err_q;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (rd_off_q == COFF_W'(k + 2)) ctrl_rd = DATA_W'(wcnt_q[k]);
      end
    end
    if (rd_is_ch_q)        rd_mux = ch_rd;
    else if (rd_is_ctrl_q) rd_mux = ctrl_rd;
    else                   rd_mux = '0;
  end

  // Next-state: read FSM, control registers, error flag and write counters.
  always_comb begin
    state_d      = state_q;
    rdata_d      = rdata_q;
    rd_is_ch_d   = rd_is_ch_q;
    rd_is_ctrl_d = rd_is_ctrl_q;
    rd_idx_d     = rd_idx_q;
    rd_off_d     = rd_off_q;
    vga_d        = vga_q;
    err_d        = err_q;
    for (int k = 0; k < N_CH; k++) wcnt_d[k] = wcnt_q[k];

    case (state_q)
      ST_IDLE: begin
        if (cpu_re && !cpu_we) begin
          state_d      = ST_RWAIT;
          rd_is_ch_d   = hit_any_ch;
          rd_is_ctrl_d = hit_ctrl;
          rd_idx_d     = ch_idx;
          rd_off_d     = ctrl_off;
        end
      end
      ST_RWAIT: begin
        state_d = ST_IDLE;
        rdata_d = rd_mux;
      end
      default: state_d = ST_IDLE;
    endcase

    wr_ctrl = cpu_we && hit_ctrl;
    if (wr_ctrl && ctrl_off == COFF_W'(0)) vga_d = cpu_wdata[0];

    // A read is only an access event on its first (IDLE) cycle; set beats clear.
    err_evt = (cpu_we && cpu_re) ||
              (unmapped && (cpu_we || (cpu_re && state_q == ST_IDLE)));
    if (wr_ctrl && ctrl_off == COFF_W'(1) && cpu_wdata[0]) err_d = 1'b0;
    if (err_evt) err_d = 1'b1;

    for (int k = 0; k < N_CH; k++) begin
      if (wr_ctrl && ctrl_off == COFF_W'(k + 2)) wcnt_d[k] = '0;
      else if (ch_we_c[k] && wcnt_q[k] != '1)     wcnt_d[k] = wcnt_q[k] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      rdata_q      <= '0;
      rd_is_ch_q   <= 1'b0;
      rd_is_ctrl_q <= 1'b0;
      rd_idx_q     <= '0;
      rd_off_q     <= '0;
      vga_q        <= 1'b0;
      err_q        <= 1'b0;
      for (int k = 0; k < N_CH; k++) wcnt_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      rdata_q      <= rdata_d;
      rd_is_ch_q   <= rd_is_ch_d;
      rd_is_ctrl_q <= rd_is_ctrl_d;
      rd_idx_q     <= rd_idx_d;
      rd_off_q     <= rd_off_d;
      vga_q        <= vga_d;
      err_q        <= err_d;
      for (int k = 0; k < N_CH; k++) wcnt_q[k] <= wcnt_d[k];
    end
  end

  // Stall only on the first cycle of a read; data is live in RWAIT, then held.
  assign cpu_ready = !(reset && state_q == ST_IDLE && cpu_re && !cpu_we);
  assign cpu_rdata = (state_q == ST_RWAIT) ? rd_mux : rdata_q;
  assign ch_adr    = ch_off[CH_AW-1:0];
  assign ch_wdata  = cpu_wdata;
  assign ch_we     = reset ? ch_we_c : '0;
  assign vga       = vga_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mmio_interconnect.sv
// Testbench for mmio_interconnect: directed accesses; read responses checked by a
// scoreboard monitor, side effects (enables, flags) checked inline.
module tb_mmio_interconnect;

  localparam logic [23:0] CH_BASE = 24'h040000;
  localparam logic [23:0] CH1     = 24'h080000;
  localparam logic [23:0] CH2     = 24'h0C0000;
  localparam logic [23:0] CTRL    = 24'h000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] cpu_adr, cpu_wdata, cpu_rdata;
  logic        cpu_we, cpu_re, cpu_ready;
  logic [17:0] ch_adr;
  logic [23:0] ch_wdata;
  logic [2:0]  ch_we;
  logic [71:0] ch_rdata;
  logic        vga, err;

  typedef struct { string nm; logic [23:0] val; } exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  mmio_interconnect dut (
    .clk(clk), .reset(reset), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .ch_adr(ch_adr), .ch_wdata(ch_wdata), .ch_we(ch_we), .ch_rdata(ch_rdata),
    .vga(vga), .err(err)
  );

  always #5 clk = ~clk;

  // Channel memories: fixed pattern, one special word in ch1, 1-cycle read latency.
  function automatic logic [23:0] mem_val(input int k, input logic [17:0] a);
    if (k == 1 && a == 18'd7) return 24'h123456;
    return {4'(k + 1), 2'b00, a};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) ch_rdata[k*24 +: 24] <= mem_val(k, ch_adr);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: a completed read is re held with ready high and no write.
  always @(negedge clk) begin
    if (reset && cpu_re && !cpu_we && cpu_ready) begin
      if (sb.size() == 0) begin
        chk("rd_unexpected", 32'(cpu_rdata), 32'hFFFF_FFFF);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk({"rd_", x.nm}, 32'(cpu_rdata), 32'(x.val));
      end
    end
  end

  task automatic wr(input logic [23:0] a, input logic [23:0] d, input logic [2:0] exp_we,
                    input logic [17:0] exp_adr, input string nm);
    cpu_adr = a; cpu_wdata = d; cpu_we = 1'b1;
    @(negedge clk);
    chk({nm, "_we"}, 32'(ch_we), 32'(exp_we));
    chk({nm, "_rdy"}, 32'(cpu_ready), 32'd1);
    if (exp_we != 3'b000) chk({nm, "_adr"}, 32'(ch_adr), 32'(exp_adr));
    @(posedge clk); #1 cpu_we = 1'b0;
  endtask

  task automatic rd(input logic [23:0] a, input logic [23:0] e, input string nm);
    bit done = 1'b0;
    int lat = 0;
    sb.push_back('{nm, e});
    cpu_adr = a; cpu_re = 1'b1;
    @(negedge clk);
    chk({nm, "_stall"}, 32'(cpu_ready), 32'd0);
    while (!done && lat < 4) begin
      @(posedge clk); #1;
      lat++;
      if (cpu_ready) done = 1'b1;
    end
    chk({nm, "_lat"}, 32'(lat), 32'd1);
    if (!done) sb.delete();
    @(posedge clk); #1 cpu_re = 1'b0;
    chk({nm, "_hold"}, 32'(cpu_rdata), 32'(e));
  endtask

  task automatic clr_err();
    wr(CTRL + 24'd1, 24'd1, 3'b000, 18'd0, "clr_err");
    chk("clr_err_flag", 32'(err), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout got 0 expected 1");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; cpu_adr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_re = 1'b0;
    #3;
    chk("reset_ready", 32'(cpu_ready), 32'd1);
    chk("reset_rdata", 32'(cpu_rdata), 32'd0);
    chk("reset_vga", 32'(vga), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_chwe", 32'(ch_we), 32'd0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    // Channel write, counter readback, channel reads
    wr(CH_BASE + 24'd5, 24'h0000AB, 3'b001, 18'd5, "t2_wr");
    rd(CTRL + 24'd2, 24'd1, "t2_wcnt0");
    rd(CH_BASE + 24'd5, 24'h100005, "ch0_rd");
    rd(CH1 + 24'd7, 24'h123456, "t3_ch1");
    rd(CH2 + 24'd3, 24'h300003, "ch2_rd");

    // Show flag
    wr(CTRL, 24'd1, 3'b000, 18'd0, "t4_vga1");
    chk("t4_vga_set", 32'(vga), 32'd1);
    rd(CTRL, 24'd1, "t4_ctrl1");
    wr(CTRL, 24'd0, 3'b000, 18'd0, "t4_vga0");
    chk("t4_vga_clr", 32'(vga), 32'd0);
    rd(CTRL, 24'd0, "t4_ctrl0");

    // Error flag: unmapped read, clear, simultaneous we&re, set-wins
    chk("t5_err_pre", 32'(err), 32'd0);
    rd(24'hFFFFFF, 24'd0, "t5_unm");
    chk("t5_err_set", 32'(err), 32'd1);
    rd(CTRL + 24'd1, 24'd1, "t5_stat1");
    clr_err();
    rd(CTRL + 24'd1, 24'd0, "t5_stat0");
    cpu_adr = CTRL; cpu_wdata = 24'd1; cpu_we = 1'b1; cpu_re = 1'b1;
    @(negedge clk);
    chk("t5_wr_rd_rdy", 32'(cpu_ready), 32'd1);
    @(posedge clk); #1 cpu_we = 1'b0; cpu_re = 1'b0;
    chk("t5_wr_rd_vga", 32'(vga), 32'd1);
    chk("t5_wr_rd_err", 32'(err), 32'd1);
    clr_err();
    cpu_adr = CTRL + 24'd1; cpu_wdata = 24'd1; cpu_we = 1'b1; cpu_re = 1'b1;
    @(posedge clk); #1 cpu_we = 1'b0; cpu_re = 1'b0;
    chk("t5_set_wins", 32'(err), 32'd1);
    clr_err();

    // Region boundaries
    wr(24'h0FFFFF, 24'd5, 3'b100, 18'h3FFFF, "top_ch2");
    chk("top_ch2_err", 32'(err), 32'd0);
    wr(24'h100000, 24'd5, 3'b000, 18'd0, "past_ch2");
    chk("past_ch2_err", 32'(err), 32'd1);
    clr_err();
    wr(24'h03FFFF, 24'd5, 3'b000, 18'd0, "below_ch0");
    chk("below_ch0_err", 32'(err), 32'd1);
    clr_err();
    wr(CTRL + 24'd5, 24'd1, 3'b000, 18'd0, "past_ctrl");
    chk("past_ctrl_err", 32'(err), 32'd1);
    clr_err();

    // Counter saturation and clear-on-write
    rd(CTRL + 24'd4, 24'd1, "t6_wcnt2_pre");
    wr(CTRL + 24'd4, 24'd0, 3'b000, 18'd0, "t6_clr");
    rd(CTRL + 24'd4, 24'd0, "t6_wcnt2_zero");
    cpu_adr = CH2; cpu_wdata = 24'h55; cpu_we = 1'b1;
    repeat (65539) @(posedge clk);
    #1 cpu_we = 1'b0;
    rd(CTRL + 24'd4, 24'h00FFFF, "t6_sat");
    wr(CTRL + 24'd4, 24'h123, 3'b000, 18'd0, "t6_clr2");
    rd(CTRL + 24'd4, 24'd0, "t6_cleared");
    rd(CTRL + 24'd2, 24'd1, "t6_wcnt0");
    rd(CTRL + 24'd3, 24'd0, "t6_wcnt1");

    // Reset in the middle of a read
    wr(CTRL, 24'd1, 3'b000, 18'd0, "t1_vga1");
    cpu_adr = CH1 + 24'd7; cpu_re = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; cpu_re = 1'b0;
    #1;
    chk("t1_rst_ready", 32'(cpu_ready), 32'd1);
    chk("t1_rst_rdata", 32'(cpu_rdata), 32'd0);
    chk("t1_rst_vga", 32'(vga), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    rd(CTRL, 24'd0, "t1_post_ctrl");
    rd(CTRL + 24'd2, 24'd0, "t1_post_wcnt0");

    repeat (2) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
